// File: rtl/multi_data_sync_pkg.sv
// multi_data_sync_pkg: default sizing and capture-mode encodings shared by the multi-channel synchronizer
package multi_data_sync_pkg;
  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_NUM_CH     = 4;
  localparam int MODE_LEVEL     = 0;
  localparam int MODE_TOGGLE    = 1;
endpackage

// File: rtl/dsync_channel.sv
// dsync_channel: one qualifier-synchronized data capture channel
// Ports: CLK/RST (async active-high); bus_enable, unsync_bus (async source side);
// sync_ready, clr_overflow (local consumer); sync_bus, enable_pulse, sync_valid,
// ack_toggle, overflow (all registered, no combinational path from async inputs).
module dsync_channel import multi_data_sync_pkg::*; #(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 sync_ready,
  input  logic                 clr_overflow,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 sync_valid,
  output logic                 ack_toggle,
  output logic                 overflow
);
  logic [NUM_STAGES-1:0] sync_q;
  logic prev, sync_out, capture;
  assign sync_out = sync_q[NUM_STAGES-1];
  always_comb capture = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_out ^ prev) : (sync_out & ~prev);
  // unsync_bus is sampled only on the capture edge, when the source guarantees it is stable
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync_q       <= '0;
      prev         <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      sync_valid   <= 1'b0;
      ack_toggle   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[NUM_STAGES-2:0], bus_enable};
      prev         <= sync_out;
      enable_pulse <= capture;
      ack_toggle   <= ack_toggle ^ capture;
      if (capture) sync_bus <= unsync_bus;
      sync_valid   <= capture | (sync_valid & ~sync_ready);
      overflow     <= (capture & sync_valid & ~sync_ready) | (overflow & ~clr_overflow);
    end
endmodule

// File: rtl/multi_data_sync.sv
// multi_data_sync: NUM_CH independent qualifier-synchronized data capture channels
// Ports: CLK/RST (async active-high); bus_enable[NUM_CH], unsync_bus[NUM_CH*BUS_WIDTH]
// (async source side); sync_ready, clr_overflow (local consumer); sync_bus, enable_pulse,
// sync_valid, ack_toggle, overflow (per channel, channel i data at [i*BUS_WIDTH +: BUS_WIDTH]).
module multi_data_sync import multi_data_sync_pkg::*; #(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           clr_overflow,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           overflow
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dsync_channel #(
      .BUS_WIDTH(BUS_WIDTH),
      .NUM_STAGES(NUM_STAGES),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_ch (
      .CLK(CLK),
      .RST(RST),
      .bus_enable(bus_enable[i]),
      .unsync_bus(unsync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
      .sync_ready(sync_ready[i]),
      .clr_overflow(clr_overflow[i]),
      .sync_bus(sync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
      .enable_pulse(enable_pulse[i]),
      .sync_valid(sync_valid[i]),
      .ack_toggle(ack_toggle[i]),
      .overflow(overflow[i])
    );
  end
endmodule

// File: tb/tb_multi_data_sync.sv
// tb_multi_data_sync: level, toggle and wide/deep instances checked against a history-based reference model
module tb_multi_data_sync;
  import multi_data_sync_pkg::*;
  logic CLK = 0, RST = 0;
  logic [3:0] be = 0, rdy = 0, clr = 0;
  logic [31:0] din = 0;
  logic be_w = 0, rdy_w = 0, clr_w = 0;
  logic [15:0] din_w = 0;
  logic [31:0] bus0, bus1;
  logic [15:0] bus2;
  logic [3:0] pl0, vl0, ak0, of0, pl1, vl1, ak1, of1;
  logic pl2, vl2, ak2, of2;
  int n_pass = 0, n_chk = 0;
  int ns[3] = '{2, 2, 3};
  int tm[3] = '{0, 1, 0};
  int nch[3] = '{4, 4, 1};
  int bw[3] = '{8, 8, 16};
  logic [7:0] hist [3][4];
  logic [15:0] m_data [3][4];
  logic [3:0] m_pulse [3], m_valid [3], m_ack [3], m_ovf [3];

  always #5 CLK = ~CLK;

  multi_data_sync #(.TOGGLE_MODE(MODE_LEVEL)) dut (
    .CLK(CLK), .RST(RST), .bus_enable(be), .unsync_bus(din), .sync_ready(rdy), .clr_overflow(clr),
    .sync_bus(bus0), .enable_pulse(pl0), .sync_valid(vl0), .ack_toggle(ak0), .overflow(of0));
  multi_data_sync #(.TOGGLE_MODE(MODE_TOGGLE)) dut_t (
    .CLK(CLK), .RST(RST), .bus_enable(be), .unsync_bus(din), .sync_ready(rdy), .clr_overflow(clr),
    .sync_bus(bus1), .enable_pulse(pl1), .sync_valid(vl1), .ack_toggle(ak1), .overflow(of1));
  multi_data_sync #(.BUS_WIDTH(16), .NUM_STAGES(3), .NUM_CH(1)) dut_w (
    .CLK(CLK), .RST(RST), .bus_enable(be_w), .unsync_bus(din_w), .sync_ready(rdy_w), .clr_overflow(clr_w),
    .sync_bus(bus2), .enable_pulse(pl2), .sync_valid(vl2), .ack_toggle(ak2), .overflow(of2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pulse[i] = 0;
      m_valid[i] = 0;
      m_ack[i] = 0;
      m_ovf[i] = 0;
      for (int c = 0; c < 4; c++) begin
        hist[i][c] = 0;
        m_data[i][c] = 0;
      end
    end
  endtask

  // hist bit n holds the qualifier as sampled n edges ago; a capture happens when the
  // sample from NUM_STAGES edges ago shows a qualifying change against the one before it
  task automatic model_edge();
    logic s, r, k, a, b, cap, consumed, overwritten;
    logic [15:0] d;
    if (RST) return;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < nch[i]; c++) begin
        s = i < 2 ? be[c] : be_w;
        r = i < 2 ? rdy[c] : rdy_w;
        k = i < 2 ? clr[c] : clr_w;
        d = i < 2 ? 16'(din[c*8 +: 8]) : din_w;
        hist[i][c] = {hist[i][c][6:0], s};
        a = hist[i][c][ns[i]];
        b = hist[i][c][ns[i]+1];
        cap = tm[i] != 0 ? (a != b) : (a && !b);
        consumed = m_valid[i][c] && r && !cap;
        overwritten = cap && m_valid[i][c] && !r;
        if (overwritten) m_ovf[i][c] = 1;
        else if (k) m_ovf[i][c] = 0;
        m_pulse[i][c] = cap;
        if (cap) begin
          m_valid[i][c] = 1;
          m_data[i][c] = d;
          m_ack[i][c] = !m_ack[i][c];
        end else if (consumed) m_valid[i][c] = 0;
      end
  endtask

  function automatic logic [63:0] bus_exp(input int i);
    logic [63:0] r = 0;
    for (int c = 0; c < nch[i]; c++) r |= 64'(m_data[i][c]) << (c * bw[i]);
    return r;
  endfunction

  task automatic check_all();
    chk("lvl_bus", bus0, bus_exp(0));
    chk("lvl_pulse", pl0, m_pulse[0]);
    chk("lvl_valid", vl0, m_valid[0]);
    chk("lvl_ack", ak0, m_ack[0]);
    chk("lvl_ovf", of0, m_ovf[0]);
    chk("tgl_bus", bus1, bus_exp(1));
    chk("tgl_pulse", pl1, m_pulse[1]);
    chk("tgl_valid", vl1, m_valid[1]);
    chk("tgl_ack", ak1, m_ack[1]);
    chk("tgl_ovf", of1, m_ovf[1]);
    chk("w_bus", bus2, bus_exp(2));
    chk("w_pulse", pl2, m_pulse[2]);
    chk("w_valid", vl2, m_valid[2]);
    chk("w_ack", ak2, m_ack[2]);
    chk("w_ovf", of2, m_ovf[2]);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic set_rst(input logic v);
    RST = v;
    if (v) model_reset();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #1 set_rst(1);
    chk("reset_bus", bus0, 0);
    chk("reset_valid", vl0, 0);
    step(3);
    set_rst(0);
    be[0] = 1;
    din[7:0] = 8'hA5;
    step(2);
    chk("r026_early", pl0[0], 0);
    step(1);
    chk("r026_data", bus0[7:0], 8'hA5);
    chk("r026_pulse", pl0[0], 1);
    chk("r026_valid", vl0[0], 1);
    chk("r026_ack", ak0[0], 1);
    step(1);
    chk("r026_once", pl0[0], 0);
    be[1] = 1;
    din[15:8] = 8'h11;
    step(4);
    be[1] = 0;
    step(3);
    be[1] = 1;
    din[15:8] = 8'h3C;
    step(4);
    chk("r027_data", bus0[15:8], 8'h3C);
    chk("r027_ovf", of0[1], 1);
    clr[1] = 1;
    step(1);
    clr[1] = 0;
    chk("r027_clr", of0[1], 0);
    be[3] = 1;
    din[31:24] = 8'h55;
    step(4);
    be[3] = 0;
    step(3);
    be[3] = 1;
    din[31:24] = 8'h77;
    step(2);
    rdy[3] = 1;
    step(1);
    rdy[3] = 0;
    chk("r028_pulse", pl0[3], 1);
    chk("r028_valid", vl0[3], 1);
    chk("r028_ovf", of0[3], 0);
    be = 0;
    step(4);
    be = 4'hF;
    din = 32'h44332211;
    step(3);
    chk("r030_bus", bus0, 32'h44332211);
    chk("r030_pulse", pl0, 4'hF);
    be = 0;
    step(4);
    be = 4'hF;
    din = 32'hDEADBEEF;
    step(1);
    set_rst(1);
    chk("r030_rst_bus", bus0, 0);
    chk("r030_rst_ack", ak0, 0);
    chk("r030_rst_pulse", pl0, 0);
    step(2);
    set_rst(0);
    step(2);
    chk("r022_early", pl0, 0);
    step(1);
    chk("r022_lvl", pl0, 4'hF);
    chk("r022_tgl", pl1, 4'hF);
    set_rst(1);
    be = 0;
    step(1);
    set_rst(0);
    step(3);
    be[2] = 1;
    step(5);
    be[2] = 0;
    step(6);
    chk("r029_tgl_ack", ak1[2], 0);
    chk("r029_lvl_ack", ak0[2], 1);
    be_w = 1;
    din_w = 16'hBEEF;
    step(3);
    chk("r031_early", pl2, 0);
    step(1);
    chk("r031_pulse", pl2, 1);
    chk("r031_data", bus2, 16'hBEEF);
    repeat (2000) begin
      be ^= 4'($urandom) & 4'($urandom);
      din = $urandom;
      rdy = 4'($urandom) & 4'($urandom);
      clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      be_w ^= 1'($urandom) & 1'($urandom);
      din_w = 16'($urandom);
      rdy_w = 1'($urandom) & 1'($urandom);
      clr_w = 1'($urandom) & 1'($urandom) & 1'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        set_rst(1);
        step(1);
        set_rst(0);
      end
      step(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_data_sync.md
MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8: data bits per channel, >=1.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2: synchronizer flops per channel, >=2.
REQ-003 The block SHALL have parameter NUM_CH, default 4: number of independent channels, >=1.
REQ-004 The block SHALL have parameter TOGGLE_MODE, default 0: 0 means a rising edge of bus_enable captures; 1 means any edge captures.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports.
- CLK  input  1  destination-domain clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- bus_enable  input  NUM_CH  per-channel asynchronous qualifier.
- unsync_bus  input  NUM_CH*BUS_WIDTH  per-channel asynchronous data; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- sync_ready  input  NUM_CH  local consumer has taken sync_bus.
- clr_overflow  input  NUM_CH  clears the sticky overflow flag.
- sync_bus  output  NUM_CH*BUS_WIDTH  captured data, same packing as unsync_bus.
- enable_pulse  output  NUM_CH  one-cycle capture strobe.
- sync_valid  output  NUM_CH  captured data not yet consumed.
- ack_toggle  output  NUM_CH  flips once per capture, for the source side to synchronize back.
- overflow  output  NUM_CH  sticky flag: unconsumed data was overwritten.

Function
REQ-006 Each channel SHALL pass bus_enable[i] through a NUM_STAGES flop chain, then one history flop (prev).
REQ-007 The capture condition SHALL be sync_out & ~prev when TOGGLE_MODE=0, and sync_out ^ prev when TOGGLE_MODE=1.
REQ-008 If bus_enable changes before CLK edge k, the capture SHALL occur at edge k+NUM_STAGES-1+1, i.e. edge k+NUM_STAGES.
REQ-009 At the capture edge: sync_bus[i] SHALL load unsync_bus[i], enable_pulse[i] SHALL be 1 for exactly one cycle, and ack_toggle[i] SHALL invert.
REQ-010 Outside the capture edge, sync_bus[i] SHALL hold its value; it SHALL never carry unsampled data.
REQ-011 sync_valid[i] SHALL set on capture and clear on a cycle where sync_ready & sync_valid & ~capture.
REQ-012 Capture with ready in the same cycle: sync_valid SHALL stay 1, new data SHALL load, and no overflow SHALL be raised.
REQ-013 Capture while sync_valid=1 and sync_ready=0: new data SHALL overwrite (newest wins) and overflow[i] SHALL set.
REQ-014 overflow[i] SHALL be sticky until clr_overflow[i]; if set and clear occur in the same cycle, set SHALL win.
REQ-015 sync_ready asserted while sync_valid=0 SHALL be ignored.
REQ-016 Channels SHALL be fully independent, with no shared state; simultaneous captures on all channels SHALL all be honoured.
REQ-017 In TOGGLE_MODE=0 a falling edge of bus_enable SHALL produce no action.
REQ-018 Back-to-back qualifying edges spaced by >=1 cycle at the sync output SHALL each produce a capture.
REQ-019 The source is responsible for holding unsync_bus stable from its qualifier edge until ack_toggle returns; the block SHALL NOT check this.

Reset
REQ-020 While RST=1, all sync flops, prev, sync_bus, enable_pulse, sync_valid, ack_toggle and overflow SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-transfer SHALL discard the in-flight capture with no pulse generated.
REQ-022 A bus_enable held at 1 through reset release SHALL be treated as an edge: one capture NUM_STAGES edges after the first post-reset edge (both modes).

Structure
REQ-023 Package multi_data_sync_pkg SHALL hold the default values of BUS_WIDTH, NUM_STAGES and NUM_CH, plus the mode encodings MODE_LEVEL=0 and MODE_TOGGLE=1.
REQ-024 One sub-module, dsync_channel (params BUS_WIDTH, NUM_STAGES, TOGGLE_MODE), SHALL implement one channel; the top SHALL instantiate it NUM_CH times via generate.
REQ-025 The design SHALL contain no combinational path from any asynchronous input to any output.

Verification
REQ-026 Default params, ch0 data 0xA5, bus_enable rises before edge 10 -> at edge 12 sync_bus[0]=0xA5, enable_pulse 1 cycle, sync_valid=1, ack_toggle 0->1.
REQ-027 Capture on ch1 with sync_ready held 0, then a second capture (0x3C) -> sync_bus=0x3C, overflow[1]=1; clr_overflow then clears it.
REQ-028 sync_ready asserted on the same cycle as a capture -> sync_valid stays 1, overflow stays 0.
REQ-029 TOGGLE_MODE=1, bus_enable 0->1->0 spaced 5 cycles -> two captures, ack_toggle ends at 0; in TOGGLE_MODE=0 the same stimulus gives one capture.
REQ-030 All 4 channels capture on the same edge with distinct data -> all four captures land correctly; RST pulsed mid-chain -> all outputs 0 and no pulse.
REQ-031 NUM_STAGES=3, BUS_WIDTH=16, NUM_CH=1 -> latency is 3 edges, and the 16-bit value 0xBEEF is captured intact.
